rf215_rx_link_ctrl: RTL and testbench
=====================================

# rf215_rx_link_ctrl

Link-training and supervision controller for the AT86RF215 LVDS I/Q receive path. It sweeps the receiver's sampling delay tap and DDR bit-order swap, and scores each setting by counting valid I/Q words over a fixed window. It then locks onto the centre of the widest passing eye and watches the locked link, retraining on loss of words. It sits beside the LVDS deserializer/framer, drives its tap, swap and reset controls, and consumes its `word_valid`/`sync_ok` outputs.

## Interface
Parameters:
- `TAP_BITS`, 4: width of tap select; NUM_TAPS = 2^TAP_BITS.
- `WIN_CYC`, 1024: cycles per measurement window.
- `PASS_MIN`, 60: minimum `word_valid` count for a window to pass.
- `SETTLE_CYC`, 64: cycles `rx_rst` is held after every tap/swap change.
- `TIMEOUT_CYC`, 4096: cycles without `word_valid` in TRACK before link loss is declared.

Ports:
- `rxclk` in 1: single clock, same domain as the receiver's word outputs.
- `rst` in 1: reset. Asynchronous, active-high.
- `enable` in 1: 1 = train and track; 0 = return to IDLE.
- `word_valid` in 1: one-cycle pulse per valid I/Q word from the receiver.
- `sync_ok` in 1: receiver framing status; used only for VERIFY.
- `tap_sel` out TAP_BITS: delay tap applied to the receiver.
- `swap_ddr` out 1: DDR bit-order swap applied to the receiver.
- `tap_load` out 1: one-cycle pulse; the delay element latches `tap_sel`.
- `rx_rst` out 1: active-high hold of the receiver framer, inverted at top level.
- `link_up` out 1: locked and words flowing.
- `train_fail` out 1: no passing setting found in either swap mode.
- `best_len` out TAP_BITS+1: width of the selected eye in taps.
- `retrain_cnt` out 8: saturating count of link losses.

## Operation
States are IDLE, SETTLE, MEASURE, EVAL, NEXT, APPLY, VERIFY, TRACK and FAIL.
- **IDLE:** `rx_rst`=1, `tap_sel`=0, `swap_ddr`=0. On `enable`=1: clear run/best registers, pulse `tap_load`, go to SETTLE.
- **SETTLE:** hold `rx_rst`=1 for SETTLE_CYC cycles, then release it. Go to MEASURE, or to VERIFY if the settle followed APPLY.
- **MEASURE:** count `word_valid` pulses for exactly WIN_CYC cycles. The counter is ceil(log2(WIN_CYC+1)) bits and saturates. Go to EVAL.
- **EVAL** (1 cycle): pass = count ≥ PASS_MIN.
  - On pass: run_len += 1. If run_len (new) > best_len, then best_len = run_len and best_start = tap_sel − run_len + 1. The comparison is strict, so on equal widths the earliest run wins.
  - On fail: run_len = 0.
  - Runs do not wrap from tap NUM_TAPS−1 to tap 0.
- **NEXT:**
  - If tap_sel < NUM_TAPS−1: tap_sel += 1, pulse `tap_load`, go to SETTLE.
  - Else if best_len > 0: go to APPLY.
  - Else if `swap_ddr`=0: set `swap_ddr`=1, tap_sel=0, clear run/best, pulse `tap_load`, go to SETTLE.
  - Else: go to FAIL.
- **APPLY:** tap_sel = best_start + ((best_len−1)>>1), i.e. floor of the centre. Pulse `tap_load`, go to SETTLE.
- **VERIFY:** one window counting `word_valid`, and additionally requiring `sync_ok`=1 on the window's last cycle.
  - On pass: go to TRACK.
  - On fail: retrain_cnt += 1 (saturating), then restart the sweep at tap 0 with `swap_ddr`=0.
- **TRACK:** `link_up`=1. A watchdog clears on every `word_valid`. When it reaches TIMEOUT_CYC: `link_up`=0, retrain_cnt += 1, restart the sweep as in VERIFY fail.
- **FAIL:** `train_fail`=1, `rx_rst`=1. Exit only when `enable`=0.
- **`enable`=0 in any state:** IDLE on the next cycle. `link_up` and `train_fail` clear, `best_len` is retained, and there is no `tap_load`.

## Timing
- Reset values: `tap_sel`=0, `swap_ddr`=0, `tap_load`=0, `rx_rst`=1, `link_up`=0, `train_fail`=0, `best_len`=0, `retrain_cnt`=0. State is IDLE.
- Asserting `rst` mid-operation forces all of the above immediately (asynchronous). Training restarts from IDLE once `rst` is released.
- All outputs are registered.
- `tap_load` rises in the same cycle that `tap_sel`/`swap_ddr` show the new value. `rx_rst` is 1 from that cycle through SETTLE_CYC cycles.
- A `word_valid` pulse is counted only in MEASURE/VERIFY cycles. Pulses during SETTLE are ignored.
- One tap step costs 1 (NEXT) + SETTLE_CYC + WIN_CYC + 1 (EVAL) cycles.
- A `word_valid` pulse in the same cycle the watchdog would hit TIMEOUT_CYC wins, and the link stays up.
- `link_up` falls in the cycle the watchdog equals TIMEOUT_CYC. `retrain_cnt` updates in the same cycle.

## Test plan
Bench parameters: TAP_BITS=3, WIN_CYC=256, PASS_MIN=12, SETTLE_CYC=8, TIMEOUT_CYC=64. The model emits `word_valid` every 16 cycles (16 per window) on passing taps and none on failing taps.

- **Single eye:** taps 2–5 pass with swap 0 → `tap_sel`=3, `best_len`=4, `swap_ddr`=0, `link_up`=1 after VERIFY. Exactly 9 `tap_load` pulses.
- **Widest and tie:** passing runs 1–2 and 5–7 → `tap_sel`=6, `best_len`=3. Passing runs 1–2 and 5–6 → `tap_sel`=1, `best_len`=2.
- **Swap fallback:** nothing passes with swap 0; tap 4 only passes with swap 1 → `swap_ddr`=1, `tap_sel`=4, `best_len`=1, `link_up`=1.
- **Failure:** nothing passes in either swap mode → `train_fail`=1 after 16 windows and `rx_rst`=1. Dropping `enable` → IDLE, `train_fail`=0.
- **Loss of link:** in TRACK, stop `word_valid` → `link_up`=0 exactly 64 cycles after the last pulse, `retrain_cnt`=1, `tap_sel`=0 with a `tap_load` pulse. A pulse arriving at cycle 64 instead keeps `link_up`=1.
- **Reset mid-operation:** assert `rst` mid-MEASURE → all outputs at reset values without waiting for a clock edge. After release with `enable`=1, the sweep restarts at tap 0.

Source files
------------

// File: rtl/rf215_rx_link_ctrl_if.sv
// Control/status bundle between the RX link-training controller and the
// LVDS deserializer/framer it supervises.
interface rf215_rx_link_ctrl_if #(
  parameter int TAP_BITS = 4
);
  logic                enable;
  logic                word_valid;
  logic                sync_ok;
  logic [TAP_BITS-1:0] tap_sel;
  logic                swap_ddr;
  logic                tap_load;
  logic                rx_rst;
  logic                link_up;
  logic                train_fail;
  logic [TAP_BITS:0]   best_len;
  logic [7:0]          retrain_cnt;

  modport master (
    input  enable, word_valid, sync_ok,
    output tap_sel, swap_ddr, tap_load, rx_rst, link_up, train_fail, best_len, retrain_cnt
  );

  modport slave (
    output enable, word_valid, sync_ok,
    input  tap_sel, swap_ddr, tap_load, rx_rst, link_up, train_fail, best_len, retrain_cnt
  );
endinterface

// File: rtl/rf215_rx_link_ctrl.sv
// AT86RF215 LVDS RX link trainer: sweeps delay tap / DDR swap, locks on the
// centre of the widest passing eye, then supervises word flow and retrains.
module rf215_rx_link_ctrl #(
  parameter int TAP_BITS    = 4,
  parameter int WIN_CYC     = 1024,
  parameter int PASS_MIN    = 60,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     rxclk,
  input  logic                     rst,
  rf215_rx_link_ctrl_if.master     lnk
);

  localparam int LW      = TAP_BITS + 1;
  localparam int WCW     = $clog2(WIN_CYC + 1);
  localparam int CNT_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_EVAL, S_NEXT, S_APPLY, S_VERIFY, S_TRACK, S_FAIL
  } state_t;

  state_t              st;
  logic                after_apply;
  logic [CW-1:0]       cyc_cnt;
  logic [WCW-1:0]      wv_cnt;
  logic [LW-1:0]       run_len;
  logic [LW-1:0]       best_len;
  logic [TAP_BITS-1:0] best_start;
  logic [TAP_BITS-1:0] tap_sel;
  logic [DW-1:0]       wd;
  logic                swap_ddr, tap_load, rx_rst, link_up, train_fail;
  logic [7:0]          retrain_cnt;

  logic [WCW-1:0]      wv_nxt;
  logic [LW-1:0]       run_nxt;
  logic [TAP_BITS-1:0] bs_new, ctr_tap;
  logic [DW-1:0]       wd_nxt;
  logic                win_end, set_end, meas_pass, ver_pass;

  always_comb begin
    wv_nxt    = (lnk.word_valid && (wv_cnt != '1)) ? wv_cnt + 1'b1 : wv_cnt;
    run_nxt   = run_len + LW'(1);
    bs_new    = TAP_BITS'(LW'(tap_sel) - run_nxt + LW'(1));
    // floor of the eye centre
    ctr_tap   = best_start + TAP_BITS'((best_len - LW'(1)) >> 1);
    wd_nxt    = wd + DW'(1);
    win_end   = (cyc_cnt == CW'(WIN_CYC - 1));
    set_end   = (cyc_cnt == CW'(SETTLE_CYC - 1));
    meas_pass = (int'(wv_cnt) >= PASS_MIN);
    ver_pass  = (int'(wv_nxt) >= PASS_MIN) && lnk.sync_ok;
  end

  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      after_apply <= 1'b0;
      cyc_cnt     <= '0;
      wv_cnt      <= '0;
      run_len     <= '0;
      best_len    <= '0;
      best_start  <= '0;
      tap_sel     <= '0;
      wd          <= '0;
      swap_ddr    <= 1'b0;
      tap_load    <= 1'b0;
      rx_rst      <= 1'b1;
      link_up     <= 1'b0;
      train_fail  <= 1'b0;
      retrain_cnt <= '0;
    end else begin
      tap_load <= 1'b0;
      if (!lnk.enable) begin
        // abandon without a tap_load; best_len kept for diagnostics
        st         <= S_IDLE;
        link_up    <= 1'b0;
        train_fail <= 1'b0;
        rx_rst     <= 1'b1;
        tap_sel    <= '0;
        swap_ddr   <= 1'b0;
        cyc_cnt    <= '0;
      end else begin
        case (st)
          S_IDLE: begin
            run_len     <= '0;
            best_len    <= '0;
            best_start  <= '0;
            tap_sel     <= '0;
            swap_ddr    <= 1'b0;
            tap_load    <= 1'b1;
            rx_rst      <= 1'b1;
            cyc_cnt     <= '0;
            after_apply <= 1'b0;
            st          <= S_SETTLE;
          end
          S_SETTLE: begin
            cyc_cnt <= cyc_cnt + CW'(1);
            if (set_end) begin
              rx_rst      <= 1'b0;
              cyc_cnt     <= '0;
              wv_cnt      <= '0;
              after_apply <= 1'b0;
              st          <= after_apply ? S_VERIFY : S_MEASURE;
            end
          end
          S_MEASURE: begin
            cyc_cnt <= cyc_cnt + CW'(1);
            wv_cnt  <= wv_nxt;
            if (win_end) begin
              cyc_cnt <= '0;
              st      <= S_EVAL;
            end
          end
          S_EVAL: begin
            // strict compare: earliest of equal-width runs is kept
            if (meas_pass) begin
              run_len <= run_nxt;
              if (run_nxt > best_len) begin
                best_len   <= run_nxt;
                best_start <= bs_new;
              end
            end else begin
              run_len <= '0;
            end
            st <= S_NEXT;
          end
          S_NEXT: begin
            if (tap_sel != '1) begin
              tap_sel  <= tap_sel + TAP_BITS'(1);
              tap_load <= 1'b1;
              rx_rst   <= 1'b1;
              st       <= S_SETTLE;
            end else if (best_len != '0) begin
              st <= S_APPLY;
            end else if (!swap_ddr) begin
              swap_ddr   <= 1'b1;
              tap_sel    <= '0;
              run_len    <= '0;
              best_len   <= '0;
              best_start <= '0;
              tap_load   <= 1'b1;
              rx_rst     <= 1'b1;
              st         <= S_SETTLE;
            end else begin
              train_fail <= 1'b1;
              rx_rst     <= 1'b1;
              st         <= S_FAIL;
            end
          end
          S_APPLY: begin
            tap_sel     <= ctr_tap;
            tap_load    <= 1'b1;
            rx_rst      <= 1'b1;
            after_apply <= 1'b1;
            cyc_cnt     <= '0;
            st          <= S_SETTLE;
          end
          S_VERIFY: begin
            cyc_cnt <= cyc_cnt + CW'(1);
            wv_cnt  <= wv_nxt;
            if (win_end) begin
              cyc_cnt <= '0;
              if (ver_pass) begin
                link_up <= 1'b1;
                wd      <= '0;
                st      <= S_TRACK;
              end else begin
                if (retrain_cnt != 8'hFF) retrain_cnt <= retrain_cnt + 8'd1;
                tap_sel    <= '0;
                swap_ddr   <= 1'b0;
                run_len    <= '0;
                best_len   <= '0;
                best_start <= '0;
                tap_load   <= 1'b1;
                rx_rst     <= 1'b1;
                st         <= S_SETTLE;
              end
            end
          end
          S_TRACK: begin
            // a word arriving on the timeout cycle keeps the link
            if (lnk.word_valid) begin
              wd <= '0;
            end else if (wd_nxt == DW'(TIMEOUT_CYC)) begin
              link_up <= 1'b0;
              if (retrain_cnt != 8'hFF) retrain_cnt <= retrain_cnt + 8'd1;
              tap_sel    <= '0;
              swap_ddr   <= 1'b0;
              run_len    <= '0;
              best_len   <= '0;
              best_start <= '0;
              cyc_cnt    <= '0;
              tap_load   <= 1'b1;
              rx_rst     <= 1'b1;
              st         <= S_SETTLE;
            end else begin
              wd <= wd_nxt;
            end
          end
          S_FAIL: begin
            train_fail <= 1'b1;
            rx_rst     <= 1'b1;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign lnk.tap_sel     = tap_sel;
  assign lnk.swap_ddr    = swap_ddr;
  assign lnk.tap_load    = tap_load;
  assign lnk.rx_rst      = rx_rst;
  assign lnk.link_up     = link_up;
  assign lnk.train_fail  = train_fail;
  assign lnk.best_len    = best_len;
  assign lnk.retrain_cnt = retrain_cnt;

endmodule

// File: tb/tb_rf215_rx_link_ctrl.sv
// Bench for rf215_rx_link_ctrl: receiver model gives word_valid every 16
// cycles on passing taps; each tap_load is scored against a planned sweep.
module tb_rf215_rx_link_ctrl;

  logic rxclk, rst;
  rf215_rx_link_ctrl_if #(.TAP_BITS(3)) ifc();

  rf215_rx_link_ctrl #(
    .TAP_BITS(3), .WIN_CYC(256), .PASS_MIN(12), .SETTLE_CYC(8), .TIMEOUT_CYC(64)
  ) dut (
    .rxclk (rxclk),
    .rst   (rst),
    .lnk   (ifc)
  );

  int         n_chk = 0, n_err = 0;
  logic [7:0] m0, m1;
  logic       kill, sb_on, pass_now;
  int         inj_at, cyc, ph, last_wv, nload;
  logic [3:0] sbq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  initial begin
    rxclk = 0;
    forever #5 rxclk = ~rxclk;
  end

  // receiver model
  initial begin
    ifc.word_valid = 0; ifc.sync_ok = 0; cyc = 0; ph = 0; last_wv = -1000;
    forever begin
      @(posedge rxclk);
      cyc++;
      #1;
      ph = (ph + 1) % 16;
      pass_now = ifc.swap_ddr ? m1[ifc.tap_sel] : m0[ifc.tap_sel];
      ifc.word_valid = ((ph == 0) && pass_now && !kill) || (inj_at == cyc + 1);
      ifc.sync_ok = pass_now;
      if (ifc.word_valid) last_wv = cyc + 1;
    end
  end

  // scoreboard consumer: every tap_load must match the next planned setting
  always @(negedge rxclk) begin
    if (sb_on && ifc.tap_load) begin
      nload++;
      chk("load_rxrst", ifc.rx_rst, 1);
      if (sbq.size() == 0) chk("load_unexpected", sbq.size(), 1);
      else chk("load_setting", {ifc.swap_ddr, ifc.tap_sel}, sbq.pop_front());
    end
  end

  task automatic plan(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] m;
    int run, best, bst;
    for (int s = 0; s < 2; s++) begin
      m = (s == 0) ? a : b;
      run = 0; best = 0; bst = 0;
      for (int t = 0; t < 8; t++) begin
        sbq.push_back(4'(s * 8 + t));
        if (m[t]) begin
          run++;
          if (run > best) begin best = run; bst = t - run + 1; end
        end else run = 0;
      end
      if (best > 0) begin
        sbq.push_back(4'(s * 8 + bst + (best - 1) / 2));
        return;
      end
    end
  endtask

  task automatic train(input logic [7:0] a, input logic [7:0] b, input int e_tap,
                       input int e_len, input int e_sw, input int e_fail, input int e_loads);
    int n;
    m0 = a; m1 = b; kill = 0; inj_at = -1; nload = 0;
    sbq.delete(); plan(a, b); sb_on = 1;
    ifc.enable = 1;
    n = 0;
    while (!(ifc.link_up || ifc.train_fail) && n < 12000) begin @(negedge rxclk); n++; end
    chk("train_done", ifc.link_up | ifc.train_fail, 1);
    if (e_fail != 0) begin
      chk("train_fail", ifc.train_fail, 1);
      chk("fail_rx_rst", ifc.rx_rst, 1);
      chk("fail_link", ifc.link_up, 0);
    end else begin
      chk("tap_sel", ifc.tap_sel, e_tap);
      chk("swap_ddr", ifc.swap_ddr, e_sw);
      chk("link_up", ifc.link_up, 1);
      chk("track_rx_rst", ifc.rx_rst, 0);
    end
    chk("best_len", ifc.best_len, e_len);
    chk("n_loads", nload, e_loads);
    chk("sb_drain", sbq.size(), 0);
  endtask

  task automatic drop(input int e_len);
    ifc.enable = 0;
    @(negedge rxclk); @(negedge rxclk);
    chk("idle_link", ifc.link_up, 0);
    chk("idle_fail", ifc.train_fail, 0);
    chk("idle_rx_rst", ifc.rx_rst, 1);
    chk("idle_best_len", ifc.best_len, e_len);
    kill = 0; inj_at = -1;
  endtask

  task automatic wait_pulse(output int l);
    int n;
    n = 0;
    while (!ifc.word_valid && n < 100) begin @(negedge rxclk); n++; end
    chk("track_pulse", ifc.word_valid, 1);
    kill = 1;
    l = last_wv;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge rxclk);
  endtask

  task automatic sb_close(input int e_loads);
    @(negedge rxclk);
    sb_on = 0;
    chk("sb_drain", sbq.size(), 0);
    chk("n_loads", nload, e_loads);
  endtask

  initial begin
    int l, n;
    rst = 1; ifc.enable = 0; m0 = 0; m1 = 0; kill = 0; inj_at = -1; sb_on = 0; nload = 0;
    repeat (3) @(negedge rxclk);
    chk("rst_tap_sel", ifc.tap_sel, 0);
    chk("rst_swap", ifc.swap_ddr, 0);
    chk("rst_tap_load", ifc.tap_load, 0);
    chk("rst_rx_rst", ifc.rx_rst, 1);
    chk("rst_link_up", ifc.link_up, 0);
    chk("rst_train_fail", ifc.train_fail, 0);
    chk("rst_best_len", ifc.best_len, 0);
    chk("rst_retrain", ifc.retrain_cnt, 0);
    rst = 0;
    @(negedge rxclk);

    // single eye, then loss of link
    train(8'h3C, 8'h00, 3, 4, 0, 0, 9);
    nload = 0; sbq.push_back(4'h0);
    wait_pulse(l);
    wait_cyc(l + 63);
    chk("loss_63_up", ifc.link_up, 1);
    wait_cyc(l + 64);
    chk("loss_64_down", ifc.link_up, 0);
    chk("loss_retrain", ifc.retrain_cnt, 1);
    chk("loss_tap_load", ifc.tap_load, 1);
    chk("loss_tap_sel", ifc.tap_sel, 0);
    sb_close(1);
    drop(0);

    // word on the timeout cycle keeps the link
    train(8'h3C, 8'h00, 3, 4, 0, 0, 9);
    nload = 0; sbq.push_back(4'h0);
    wait_pulse(l);
    inj_at = l + 64;
    wait_cyc(l + 64);
    chk("edge_keep_up", ifc.link_up, 1);
    chk("edge_retrain", ifc.retrain_cnt, 1);
    wait_cyc(l + 127);
    chk("edge_127_up", ifc.link_up, 1);
    wait_cyc(l + 128);
    chk("edge_128_down", ifc.link_up, 0);
    chk("edge_retrain2", ifc.retrain_cnt, 2);
    sb_close(1);
    drop(0);

    // widest eye, tie, swap fallback, total failure
    train(8'hE6, 8'h00, 6, 3, 0, 0, 9);
    drop(3);
    train(8'h66, 8'h00, 1, 2, 0, 0, 9);
    drop(2);
    train(8'h00, 8'h10, 4, 1, 1, 0, 17);
    drop(1);
    train(8'h00, 8'h00, 0, 0, 0, 1, 16);
    drop(0);

    // asynchronous reset mid-MEASURE
    m0 = 8'h3C; m1 = 8'h00; sb_on = 0; ifc.enable = 1;
    n = 0;
    while (!(ifc.tap_sel == 3'd2 && !ifc.rx_rst) && n < 3000) begin @(negedge rxclk); n++; end
    chk("mid_measure", {ifc.tap_sel, ifc.rx_rst}, {3'd2, 1'b0});
    repeat (40) @(negedge rxclk);
    #3 rst = 1;
    #1;
    chk("arst_tap_sel", ifc.tap_sel, 0);
    chk("arst_swap", ifc.swap_ddr, 0);
    chk("arst_tap_load", ifc.tap_load, 0);
    chk("arst_rx_rst", ifc.rx_rst, 1);
    chk("arst_link_up", ifc.link_up, 0);
    chk("arst_train_fail", ifc.train_fail, 0);
    chk("arst_best_len", ifc.best_len, 0);
    chk("arst_retrain", ifc.retrain_cnt, 0);
    sbq.delete(); nload = 0; plan(8'h3C, 8'h00); sb_on = 1;
    @(negedge rxclk);
    rst = 0;
    n = 0;
    while (!ifc.link_up && n < 12000) begin @(negedge rxclk); n++; end
    chk("post_rst_link", ifc.link_up, 1);
    chk("post_rst_tap", ifc.tap_sel, 3);
    chk("post_rst_loads", nload, 9);
    chk("post_rst_drain", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
